// File: rtl/video_deserializer.sv
// rtl/video_deserializer.sv - serial dot stream to tagged 16-bit words with a 2-entry FIFO
//
// Regroups dots sampled on pixel_clk_i into 16-bit words, first dot in bit 15.
// Each word is tagged with its word column and scanline. Words are staged in
// one register and then written to a first-word-fall-through FIFO, so a word
// reaches the FIFO head one clock after its last dot is sampled.

module video_deserializer #(
   parameter int COL_W = 7,
   parameter int ROW_W = 9
) (
   input  logic             pixel_clk_i,
   input  logic             reset_n_i,
   input  logic             video_i,
   input  logic             display_en_i,
   input  logic             vsync_i,
   output logic [15:0]      word_o,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             partial_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overflow_o
);

   typedef enum logic [1:0] {SYNC, WAIT_ROW, SHIFT} state_t;

   state_t             state;
   logic               de_q;
   logic               vs_q;
   logic [15:0]        sr;
   logic [3:0]         bit_cnt;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;

   // Staging register between the capture logic and the FIFO
   logic               push_q;
   logic [15:0]        push_word;
   logic [COL_W-1:0]   push_col;
   logic [ROW_W-1:0]   push_row;
   logic               push_partial;

   // FIFO storage
   logic [15:0]        mem_word [2];
   logic [COL_W-1:0]   mem_col  [2];
   logic [ROW_W-1:0]   mem_row  [2];
   logic               mem_part [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic               overflow_q;

   logic               de_rise;
   logic               de_fall;
   logic               vs_rise;
   logic [15:0]        sr_next;
   logic [4:0]         pad;
   logic               full;
   logic               pop;
   logic               do_push;

   assign de_rise = display_en_i & ~de_q;
   assign de_fall = ~display_en_i & de_q;
   assign vs_rise = vsync_i & ~vs_q;
   assign sr_next = {sr[14:0], video_i};
   // Left-justify a short word so its first dot still lands in bit 15
   assign pad     = 5'd16 - {1'b0, bit_cnt};

   assign full    = (count == 2'd2);
   assign pop     = valid_o & ready_i;
   // A full FIFO still accepts a word when the head leaves on the same edge
   assign do_push = push_q & (~full | pop);

   // Frame/row tracking, dot shifting and word completion
   always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= SYNC;
         de_q         <= 1'b0;
         vs_q         <= 1'b0;
         sr           <= '0;
         bit_cnt      <= '0;
         col          <= '0;
         row          <= '0;
         push_q       <= 1'b0;
         push_word    <= '0;
         push_col     <= '0;
         push_row     <= '0;
         push_partial <= 1'b0;
      end else begin
         de_q   <= display_en_i;
         vs_q   <= vsync_i;
         push_q <= 1'b0;
         if (vs_rise) begin
            // New frame: any word in progress is abandoned
            row     <= '0;
            col     <= '0;
            bit_cnt <= '0;
            state   <= WAIT_ROW;
         end else begin
            case (state)
               SYNC: begin
               end
               WAIT_ROW: begin
                  if (de_rise) begin
                     sr      <= {15'd0, video_i};
                     bit_cnt <= 4'd1;
                     col     <= '0;
                     state   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (display_en_i) begin
                     sr <= sr_next;
                     if (bit_cnt == 4'd15) begin
                        push_q       <= 1'b1;
                        push_word    <= sr_next;
                        push_col     <= col;
                        push_row     <= row;
                        push_partial <= 1'b0;
                        bit_cnt      <= '0;
                        col          <= col + 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end else if (de_fall) begin
                     if (bit_cnt != 4'd0) begin
                        push_q       <= 1'b1;
                        push_word    <= sr << pad;
                        push_col     <= col;
                        push_row     <= row;
                        push_partial <= 1'b1;
                     end
                     row   <= row + 1'b1;
                     state <= WAIT_ROW;
                  end
               end
               default: state <= SYNC;
            endcase
         end
      end
   end

   // Two-entry FIFO with sticky overflow; a drop on a vs_rise cycle keeps the flag set
   always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_word[i] <= '0;
            mem_col[i]  <= '0;
            mem_row[i]  <= '0;
            mem_part[i] <= 1'b0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            mem_word[wr_ptr] <= push_word;
            mem_col[wr_ptr]  <= push_col;
            mem_row[wr_ptr]  <= push_row;
            mem_part[wr_ptr] <= push_partial;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (push_q && full && !pop) begin
            overflow_q <= 1'b1;
         end else if (vs_rise) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign valid_o    = (count != 2'd0);
   assign word_o     = valid_o ? mem_word[rd_ptr] : '0;
   assign col_o      = valid_o ? mem_col[rd_ptr]  : '0;
   assign row_o      = valid_o ? mem_row[rd_ptr]  : '0;
   assign partial_o  = valid_o ? mem_part[rd_ptr] : 1'b0;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_video_deserializer.sv
// tb/tb_video_deserializer.sv - scoreboard bench for video_deserializer

module tb_video_deserializer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        video;
   logic        de;
   logic        vs;
   logic        ready;
   logic [15:0] word;
   logic [6:0]  col;
   logic [8:0]  row;
   logic        partial;
   logic        valid;
   logic        overflow;

   typedef struct packed {
      logic [15:0] w;
      logic [6:0]  c;
      logic [8:0]  r;
      logic        p;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   video_deserializer #(.COL_W(7), .ROW_W(9)) dut (
      .pixel_clk_i  (clk),
      .reset_n_i    (reset_n),
      .video_i      (video),
      .display_en_i (de),
      .vsync_i      (vs),
      .word_o       (word),
      .col_o        (col),
      .row_o        (row),
      .partial_o    (partial),
      .valid_o      (valid),
      .ready_i      (ready),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every accepted word is compared against the scoreboard head
   always @(negedge clk) begin
      exp_t got;
      exp_t e;
      if (reset_n && valid && ready) begin
         got = {word, col, row, partial};
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %h expected none", got);
         end else begin
            e = sb.pop_front();
            chk("word", got, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [15:0] w, input int c, input int r, input logic p);
      exp_t e;
      e = {w, 7'(c), 9'(r), p};
      sb.push_back(e);
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) begin
         video = w[i];
         de    = 1'b1;
         tick();
      end
   endtask

   task automatic de_low(input int n);
      de    = 1'b0;
      video = 1'b0;
      repeat (n) tick();
   endtask

   task automatic vs_pulse();
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      chk(name, sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] two_words;
      logic [47:0] three_words;
      logic        seen;
      logic [15:0] w;

      reset_n = 1'b0;
      video   = 1'b0;
      de      = 1'b0;
      vs      = 1'b0;
      ready   = 1'b1;
      repeat (3) tick();
      chk("reset_outputs", {word, col, row, partial, valid, overflow}, 0);
      reset_n = 1'b1;
      tick();

      // Two full words, with capture latency checked around the first
      vs_pulse();
      de_low(2);
      expect_word(16'hA5C3, 0, 0, 1'b0);
      expect_word(16'hFFFF, 1, 0, 1'b0);
      two_words = 32'hA5C3_FFFF;
      for (int i = 0; i < 32; i++) begin
         video = two_words[31-i];
         de    = 1'b1;
         tick();
         if (i == 15) chk("latency_pre", valid, 1'b0);
         if (i == 16) begin
            chk("latency_post", valid, 1'b1);
            chk("latency_word", word, 16'hA5C3);
         end
      end
      de_low(3);
      drain("drain_two_words");

      // 20 dots: one full word plus a 4-dot partial on row 1
      expect_word(16'hFFFF, 0, 1, 1'b0);
      expect_word(16'hF000, 1, 1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         video = 1'b1;
         de    = 1'b1;
         tick();
      end
      de_low(3);
      drain("drain_partial");

      // Backpressure: third word dropped, overflow sticky until vs_rise
      ready = 1'b0;
      expect_word(16'h1234, 0, 2, 1'b0);
      expect_word(16'h5678, 1, 2, 1'b0);
      three_words = 48'h1234_5678_9ABC;
      for (int i = 0; i < 48; i++) begin
         video = three_words[47-i];
         de    = 1'b1;
         tick();
      end
      de_low(4);
      chk("overflow_set", overflow, 1'b1);
      chk("held_valid", valid, 1'b1);
      chk("held_head", {word, col, row, partial}, {16'h1234, 7'd0, 9'd2, 1'b0});
      ready = 1'b1;
      drain("drain_overflow");
      chk("overflow_still_set", overflow, 1'b1);
      vs_pulse();
      chk("overflow_cleared", overflow, 1'b0);

      // vs_rise five dots into a word: discarded, capture waits for de_rise
      for (int i = 0; i < 5; i++) begin
         video = 1'b1;
         de    = 1'b1;
         tick();
      end
      vs = 1'b1;
      tick();
      vs = 1'b0;
      for (int i = 0; i < 20; i++) begin
         video = 1'b1;
         de    = 1'b1;
         tick();
      end
      de_low(3);
      chk("no_push_after_vs", sb.size(), 0);
      expect_word(16'hC0DE, 0, 0, 1'b0);
      send_word(16'hC0DE);
      de_low(3);
      drain("drain_after_vs");

      // Asynchronous reset with one word held in the FIFO
      ready = 1'b0;
      send_word(16'h7777);
      for (int i = 0; i < 5; i++) begin
         video = 1'b1;
         de    = 1'b1;
         tick();
      end
      chk("pre_reset_valid", valid, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_async", {word, col, row, partial, valid, overflow}, 0);
      de    = 1'b0;
      video = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      ready   = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         video = 1'b1;
         de    = 1'b1;
         tick();
         seen = seen | valid;
      end
      de = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen = seen | valid;
      end
      chk("no_push_before_vs", seen, 1'b0);

      // Dot-generator style loopback: 40 words x 2 rows
      vs_pulse();
      de_low(2);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 40; c++) begin
            w = 16'(c * 16'h1357 + r * 16'h0F0F + 16'h0101);
            expect_word(w, c, r, 1'b0);
            send_word(w);
         end
         de_low(6);
      end
      drain("drain_loopback");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/video_deserializer.md
# video_deserializer

Captures a serial dot stream, such as the PET video output or an external reference machine's video, on the pixel clock. It regroups the dots into 16-bit words, MSB first, matching the dot generator's shift order. Each word is tagged with its column and row and delivered through a 2-entry valid/ready FIFO. Its uses are frame capture, comparison against video RAM, and closed-loop checking of the dot generator.

## Interface
- COL_W, default 7: width of the word-column counter (80-column rows use 40 words).
- ROW_W, default 9: width of the scanline counter.
- pixel_clk_i, in, 1: pixel clock; the only clock.
- reset_n_i, in, 1: asynchronous active-low reset.
- video_i, in, 1: serial dot, sampled on the rising edge.
- display_en_i, in, 1: high while active dots are on video_i. Synchronous to pixel_clk_i.
- vsync_i, in, 1: frame sync; the rising edge starts a frame. Synchronous to pixel_clk_i.
- word_o, out, 16: captured dots; the first dot of the word is in bit 15.
- col_o, out, COL_W: word index within the row.
- row_o, out, ROW_W: scanline index within the frame.
- partial_o, out, 1: the word was closed early by the falling edge of display_en_i; unfilled LSBs are 0.
- valid_o, out, 1: the FIFO head is valid.
- ready_i, in, 1: the consumer accepts the head when valid_o & ready_i.
- overflow_o, out, 1: sticky flag; a completed word was dropped because the FIFO was full.

## Operation
- Edge detection uses registered copies of display_en_i and vsync_i:
  - de_rise/de_fall compare display_en_i against its registered copy.
  - vs_rise compares vsync_i against its registered copy.
- States:
  - SYNC: entered from reset. Waits for vs_rise, then goes to WAIT_ROW.
  - WAIT_ROW: on de_rise, goes to SHIFT. The dot on that cycle is shifted in, bit count = 1 and col = 0.
  - SHIFT: while display_en_i=1, shift video_i into the LSB of the shift register and increment the bit count.
- Word completion in SHIFT:
  - When the 16th bit is shifted in, push {sr, col, row, partial=0} to the FIFO.
  - Then set bit count = 0 and col = col + 1. col wraps modulo 2^COL_W.
- Falling edge of display_en_i in SHIFT:
  - If bit count ≠ 0, push {sr << (16 − count), col, row, partial=1}.
  - In all cases, row = row + 1 (wraps modulo 2^ROW_W), then go to WAIT_ROW.
- vs_rise in any state:
  - row = 0, col = 0, bit count = 0.
  - Clear overflow_o.
  - Go to WAIT_ROW. A partial word in progress is discarded, not pushed.
  - If display_en_i is high on vs_rise, capture waits for the next de_rise.
- FIFO behaviour:
  - 2 entries, first-word fall-through.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
  - A push into a full FIFO without a pop drops the new word and sets overflow_o.
  - If overflow is set on the same cycle as vs_rise, set wins.
- Ignored events:
  - A de_rise while already in SHIFT is impossible; no check is required.
  - de_rise and de_fall in SYNC are ignored, and nothing is pushed.

## Timing
- Reset values:
  - Outputs: word_o=0, col_o=0, row_o=0, partial_o=0, valid_o=0, overflow_o=0.
  - Internal: state=SYNC, FIFO empty.
- Capture latency: a word whose 16th dot is sampled at edge N appears at the FIFO head with valid_o=1 after edge N+1.
  - The same applies to a partial word: the de_fall cycle is sampled at edge N, and the word is visible after edge N+1.
- Throughput: one word per 16 clocks. This is sustained with ready_i tied high.
- word_o, col_o, row_o and partial_o are stable while valid_o=1 and ready_i=0.
- Asynchronous reset mid-row:
  - All state clears immediately.
  - After release, nothing is pushed until vs_rise, and then de_rise.

## Test plan
- Reset, vs_rise, then display_en high for 32 clocks with dots 0xA5C3 followed by 0xFFFF, ready_i=1:
  - Word 0x0A5C3 with col 0, row 0, partial 0, valid one clock after its 16th dot.
  - Word 0xFFFF with col 1.
  - Row increments to 1 after de_fall.
- display_en high for 20 clocks, all dots 1:
  - One full word 0xFFFF.
  - A second word 0xF000 with partial_o=1 and col 1.
- ready_i=0 for 3 complete words:
  - The first two are held in order.
  - The third is dropped and overflow_o=1.
  - The next vs_rise clears overflow_o.
- vs_rise 5 dots into a word:
  - Nothing is pushed.
  - row_o and col_o return to 0 on the next captured word.
  - Capture resumes only at the next de_rise.
- reset_n_i pulsed low mid-row with the FIFO holding 1 word:
  - All outputs are 0 immediately.
  - No word is pushed on the following de_rise until a vs_rise occurs.
- Loopback from the dot generator (with reverse=0 and enable=1) across 40 words × 2 rows:
  - Every captured word equals the corresponding pixels_i value.
  - col runs 0..39, and row is 0 then 1.
